serial_pattern_gen: RTL

Serial pattern transmitter that drives a one-bit stream into the team's sequence-detector FSMs (the Moore/Mealy 1010 detectors). On a start request it shifts a fixed parameter pattern out MSB-first, one bit per clock, repeated a programmable number of times with a programmable idle gap between repetitions. It is the stimulus source for the detectors in the FSM task: its `dout` connects directly to a detector's `din`.

---
 rtl/serial_pattern_gen_if.sv | 20 ++
 rtl/serial_pattern_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if: control inputs and serial stream outputs of serial_pattern_gen
interface serial_pattern_gen_if;
  logic       start;
  logic       abort;
  logic [7:0] rep_cnt;
  logic [3:0] gap_len;
  logic       dout;
  logic       dout_valid;
  logic       last_bit;
  logic       busy;
  logic       done;
  modport master (
    output start, abort, rep_cnt, gap_len,
    input  dout, dout_valid, last_bit, busy, done
  );
  modport slave (
    input  start, abort, rep_cnt, gap_len,
    output dout, dout_valid, last_bit, busy, done
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: shifts PATTERN out MSB-first rep_cnt times with gap_len idle cycles between repetitions
module serial_pattern_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter logic             GAP_BIT = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_pattern_gen_if.slave bus
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    rep_q, rep_d;
  logic [3:0]    gap_len_q, gap_len_d;
  logic [3:0]    gap_q, gap_d;
  logic          dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          last_bit_q, last_bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_d     = gap_q;
    case (state_q)
      IDLE: if (bus.start && bus.rep_cnt != 8'd0) begin
        state_d   = SHIFT;
        idx_d     = TOP;
        rep_d     = bus.rep_cnt;
        gap_len_d = bus.gap_len;
      end
      SHIFT: if (idx_q != '0) begin
        idx_d = idx_q - IW'(1);
      end else begin
        rep_d   = rep_q - 8'd1;
        state_d = rep_q == 8'd1 ? DONE : gap_len_q == 4'd0 ? SHIFT : GAP;
        idx_d   = rep_q == 8'd1 ? '0 : TOP;
        gap_d   = rep_q == 8'd1 ? 4'd0 : gap_len_q;
      end
      GAP: begin
        state_d = gap_q == 4'd1 ? SHIFT : GAP;
        gap_d   = gap_q - 4'd1;
      end
      DONE: begin
        state_d   = IDLE;
        gap_len_d = '0;
      end
    endcase
    if (bus.abort && (state_q == SHIFT || state_q == GAP)) begin
      state_d   = IDLE;
      idx_d     = '0;
      rep_d     = '0;
      gap_d     = '0;
      gap_len_d = '0;
    end
    dout_d       = state_d == SHIFT ? PATTERN[idx_d] : GAP_BIT;
    dout_valid_d = state_d == SHIFT;
    last_bit_d   = state_d == SHIFT && idx_d == '0;
    busy_d       = state_d == SHIFT || state_d == GAP;
    done_d       = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rep_q        <= '0;
      gap_len_q    <= '0;
      gap_q        <= '0;
      dout_q       <= GAP_BIT;
      dout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rep_q        <= rep_d;
      gap_len_q    <= gap_len_d;
      gap_q        <= gap_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_bit_q   <= last_bit_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.last_bit   = last_bit_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
